// File: rtl/cpu_pipeline_pkg.sv
// Shared pipeline definitions: IF/ID register layout, the bubble instruction
// and the fetch-stage state encoding.
package cpu_pipeline_pkg;

    localparam logic [31:0] BUBBLE_INSTR = 32'h910003FF;

    localparam int IFID_W        = 96;
    localparam int IFID_PC_HI    = 95;
    localparam int IFID_PC_LO    = 32;
    localparam int IFID_INSTR_HI = 31;
    localparam int IFID_INSTR_LO = 0;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/Adder_64.sv
// Plain 64-bit modulo adder shared by the datapath.
module Adder_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_next_pc.sv
// Next-PC priority selector: live branch, then pending branch, then PC + 4.
module fetch_next_pc (
    input  logic        br_taken_i,
    input  logic        stall_i,
    input  logic [63:0] br_target_i,
    input  logic        pend_br_i,
    input  logic [63:0] pend_target_i,
    input  logic [63:0] pc_i,
    output logic [63:0] next_pc_o
);

    logic [63:0] pc_plus4;
    logic [63:0] sel_pc;

    Adder_64 u_pc_inc (
        .a_i   (pc_i),
        .b_i   (64'd4),
        .sum_o (pc_plus4)
    );

    always_comb begin
        sel_pc = pc_plus4;
        if (br_taken_i && !stall_i) begin
            sel_pc = br_target_i;
        end else if (pend_br_i) begin
            sel_pc = pend_target_i;
        end
        // Instructions are word aligned; low bits of any target are dropped.
        next_pc_o = {sel_pc[63:2], 2'b00};
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, variable-latency imem handshake, IF/ID register with
// bubble insertion, decode-stall hold buffer and delay-slot branch handling.
module instruction_fetch_unit
    import cpu_pipeline_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall_Ctrl,
    input  logic               BrTaken_Ctrl,
    input  logic [63:0]        BRANCH_TARGET_ADDRESS,
    output logic               IMEM_Req,
    output logic [63:0]        IMEM_Addr,
    input  logic               IMEM_Ready,
    input  logic [31:0]        IMEM_Data,
    output logic [IFID_W-1:0]  INSTRUCTION_PIPELINE_REG
);

    fetch_state_t      state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic              pend_br_q, pend_br_d;
    logic [63:0]       pend_tgt_q, pend_tgt_d;
    logic [31:0]       hold_q, hold_d;
    logic [IFID_W-1:0] ifid_q, ifid_d;
    logic [63:0]       next_pc;
    logic              complete;

    fetch_next_pc u_next_pc (
        .br_taken_i    (BrTaken_Ctrl),
        .stall_i       (Stall_Ctrl),
        .br_target_i   (BRANCH_TARGET_ADDRESS),
        .pend_br_i     (pend_br_q),
        .pend_target_i (pend_tgt_q),
        .pc_i          (pc_q),
        .next_pc_o     (next_pc)
    );

    assign complete = !Stall_Ctrl &&
                      ((state_q == S_HOLD) || ((state_q == S_FETCH) && IMEM_Ready));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_br_d  = pend_br_q;
        pend_tgt_d = pend_tgt_q;
        hold_d     = hold_q;
        ifid_d     = ifid_q;

        if (state_q == S_FETCH) begin
            if (IMEM_Ready && Stall_Ctrl) begin
                hold_d  = IMEM_Data;
                state_d = S_HOLD;
            end else if (!IMEM_Ready && !Stall_Ctrl) begin
                ifid_d[IFID_PC_HI:IFID_PC_LO]       = pc_q;
                ifid_d[IFID_INSTR_HI:IFID_INSTR_LO] = BUBBLE_INSTR;
            end
        end

        if (complete) begin
            ifid_d[IFID_PC_HI:IFID_PC_LO]       = pc_q;
            ifid_d[IFID_INSTR_HI:IFID_INSTR_LO] = (state_q == S_HOLD) ? hold_q : IMEM_Data;
            pc_d      = next_pc;
            pend_br_d = 1'b0;
            state_d   = S_FETCH;
        end else if (BrTaken_Ctrl && !Stall_Ctrl) begin
            // Delay slot still in flight: remember the target until it lands.
            pend_br_d  = 1'b1;
            pend_tgt_d = BRANCH_TARGET_ADDRESS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pend_br_q  <= 1'b0;
            pend_tgt_q <= 64'd0;
            hold_q     <= 32'd0;
            ifid_q     <= {64'd0, BUBBLE_INSTR};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_br_q  <= pend_br_d;
            pend_tgt_q <= pend_tgt_d;
            hold_q     <= hold_d;
            ifid_q     <= ifid_d;
        end
    end

    assign IMEM_Req                 = (state_q == S_FETCH) && !reset;
    assign IMEM_Addr                = pc_q;
    assign INSTRUCTION_PIPELINE_REG = ifid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage: vector table plus a reset-mid-wait sequence.
module tb_instruction_fetch_unit;

    localparam logic [31:0] B = 32'h910003FF;

    logic        clk;
    logic        reset;
    logic        Stall_Ctrl;
    logic        BrTaken_Ctrl;
    logic [63:0] BRANCH_TARGET_ADDRESS;
    logic        IMEM_Req;
    logic [63:0] IMEM_Addr;
    logic        IMEM_Ready;
    logic [31:0] IMEM_Data;
    logic [95:0] INSTRUCTION_PIPELINE_REG;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic        rdy;
        logic [31:0] data;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        logic [31:0] exp_ins;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch_unit #(.RESET_PC(64'd0)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .Stall_Ctrl               (Stall_Ctrl),
        .BrTaken_Ctrl             (BrTaken_Ctrl),
        .BRANCH_TARGET_ADDRESS    (BRANCH_TARGET_ADDRESS),
        .IMEM_Req                 (IMEM_Req),
        .IMEM_Addr                (IMEM_Addr),
        .IMEM_Ready               (IMEM_Ready),
        .IMEM_Data                (IMEM_Data),
        .INSTRUCTION_PIPELINE_REG (INSTRUCTION_PIPELINE_REG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic stall, input logic br, input logic [63:0] tgt,
                       input logic rdy, input logic [31:0] data,
                       input logic req, input logic [63:0] addr,
                       input logic [63:0] pc, input logic [31:0] ins, input logic pend);
        vec_t v;
        v.stall = stall; v.br = br; v.tgt = tgt; v.rdy = rdy; v.data = data;
        v.exp_req = req; v.exp_addr = addr; v.exp_pc = pc; v.exp_ins = ins; v.exp_pend = pend;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        Stall_Ctrl = 1'b0;
        BrTaken_Ctrl = 1'b0;
        BRANCH_TARGET_ADDRESS = 64'd0;
        IMEM_Ready = 1'b0;
        IMEM_Data = 32'd0;

        //   stall br  tgt                     rdy data           req addr                    IF/ID pc                IF/ID instr   pend
        add(0, 0, 64'h0,                 1, 32'hA5A50000, 1, 64'h0,                 64'h0,                 32'hA5A50000, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A50004, 1, 64'h4,                 64'h4,                 32'hA5A50004, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A50008, 1, 64'h8,                 64'h8,                 32'hA5A50008, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A5000C, 1, 64'hC,                 64'hC,                 32'hA5A5000C, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A50010, 1, 64'h10,                64'h10,                32'hA5A50010, 0);
        add(0, 1, 64'h100,               1, 32'hA5A50014, 1, 64'h14,                64'h14,                32'hA5A50014, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A50100, 1, 64'h100,               64'h100,               32'hA5A50100, 0);
        add(0, 0, 64'h0,                 1, 32'hA5A50104, 1, 64'h104,               64'h104,               32'hA5A50104, 0);
        add(0, 1, 64'h20,                1, 32'hA5A50108, 1, 64'h108,               64'h108,               32'hA5A50108, 0);
        add(0, 0, 64'h0,                 0, 32'h0,        1, 64'h20,                64'h20,                B,            0);
        add(0, 0, 64'h0,                 0, 32'h0,        1, 64'h20,                64'h20,                B,            0);
        add(0, 0, 64'h0,                 1, 32'h11112020, 1, 64'h20,                64'h20,                32'h11112020, 0);
        add(0, 1, 64'h8,                 1, 32'h11112024, 1, 64'h24,                64'h24,                32'h11112024, 0);
        add(1, 1, 64'h500,               1, 32'h22220008, 1, 64'h8,                 64'h24,                32'h11112024, 0);
        add(1, 0, 64'h0,                 0, 32'h0,        0, 64'h8,                 64'h24,                32'h11112024, 0);
        add(0, 0, 64'h0,                 0, 32'h0,        0, 64'h8,                 64'h8,                 32'h22220008, 0);
        add(0, 0, 64'h0,                 1, 32'h2222000C, 1, 64'hC,                 64'hC,                 32'h2222000C, 0);
        add(0, 0, 64'h0,                 1, 32'h33330010, 1, 64'h10,                64'h10,                32'h33330010, 0);
        add(0, 1, 64'h300,               0, 32'h0,        1, 64'h14,                64'h14,                B,            1);
        add(0, 1, 64'h100,               0, 32'h0,        1, 64'h14,                64'h14,                B,            1);
        add(0, 0, 64'h0,                 0, 32'h0,        1, 64'h14,                64'h14,                B,            1);
        add(0, 0, 64'h0,                 1, 32'h33330014, 1, 64'h14,                64'h14,                32'h33330014, 0);
        add(0, 0, 64'h0,                 1, 32'h33330100, 1, 64'h100,               64'h100,               32'h33330100, 0);
        add(0, 1, 64'hFFFFFFFFFFFFFFFC,  1, 32'h33330104, 1, 64'h104,               64'h104,               32'h33330104, 0);
        add(0, 0, 64'h0,                 1, 32'h4444FFFC, 1, 64'hFFFFFFFFFFFFFFFC,  64'hFFFFFFFFFFFFFFFC,  32'h4444FFFC, 0);
        add(0, 1, 64'h203,               1, 32'h44440000, 1, 64'h0,                 64'h0,                 32'h44440000, 0);
        add(0, 0, 64'h0,                 1, 32'h44440200, 1, 64'h200,               64'h200,               32'h44440200, 0);
        add(0, 1, 64'h40,                1, 32'h44440204, 1, 64'h204,               64'h204,               32'h44440204, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",  {95'd0, IMEM_Req}, 96'd0);
        chk("reset_addr", {32'd0, IMEM_Addr}, 96'd0);
        chk("reset_ifid", INSTRUCTION_PIPELINE_REG, {64'd0, B});
        chk("reset_pend", {95'd0, dut.pend_br_q}, 96'd0);
        reset = 1'b0;
        #1;
        chk("first_req", {95'd0, IMEM_Req}, 96'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            Stall_Ctrl            = vecs[i].stall;
            BrTaken_Ctrl          = vecs[i].br;
            BRANCH_TARGET_ADDRESS = vecs[i].tgt;
            IMEM_Ready            = vecs[i].rdy;
            IMEM_Data             = vecs[i].data;
            #1;
            chk($sformatf("v%0d_req", i),  {95'd0, IMEM_Req}, {95'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), {32'd0, IMEM_Addr}, {32'd0, vecs[i].exp_addr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ifid", i), INSTRUCTION_PIPELINE_REG, {vecs[i].exp_pc, vecs[i].exp_ins});
            chk($sformatf("v%0d_pend", i), {95'd0, dut.pend_br_q}, {95'd0, vecs[i].exp_pend});
        end

        // Reset asserted while a fetch at 0x40 is waiting on memory.
        @(negedge clk);
        Stall_Ctrl = 1'b0; BrTaken_Ctrl = 1'b0; BRANCH_TARGET_ADDRESS = 64'd0;
        IMEM_Ready = 1'b0; IMEM_Data = 32'd0;
        #1;
        chk("rst_pre_addr", {32'd0, IMEM_Addr}, {32'd0, 64'h40});
        chk("rst_pre_req",  {95'd0, IMEM_Req}, 96'd1);
        @(posedge clk);
        #1;
        chk("rst_pre_ifid", INSTRUCTION_PIPELINE_REG, {64'h40, B});
        @(negedge clk);
        #1;
        reset = 1'b1;
        IMEM_Ready = 1'b1; IMEM_Data = 32'h55550040;
        #1;
        chk("rst_mid_req",  {95'd0, IMEM_Req}, 96'd0);
        chk("rst_mid_addr", {32'd0, IMEM_Addr}, 96'd0);
        chk("rst_mid_ifid", INSTRUCTION_PIPELINE_REG, {64'd0, B});
        @(posedge clk);
        #1;
        chk("rst_hold_ifid", INSTRUCTION_PIPELINE_REG, {64'd0, B});
        chk("rst_hold_req",  {95'd0, IMEM_Req}, 96'd0);
        @(negedge clk);
        reset = 1'b0;
        IMEM_Ready = 1'b1; IMEM_Data = 32'h66660000;
        #1;
        chk("rst_rel_req",  {95'd0, IMEM_Req}, 96'd1);
        chk("rst_rel_addr", {32'd0, IMEM_Addr}, 96'd0);
        @(posedge clk);
        #1;
        chk("rst_rel_ifid", INSTRUCTION_PIPELINE_REG, {64'd0, 32'h66660000});
        chk("rst_rel_next", {32'd0, IMEM_Addr}, {32'd0, 64'h4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the pipelined CPU, directly upstream of the register/decode stage. Holds the program counter and issues requests to a variable-latency instruction memory over a req/ready handshake. Drives the 96-bit IF/ID pipeline register `{PC, instruction}` and inserts bubbles while memory is slow. Honours decode-stage stalls and applies decode-resolved branches after exactly one delay-slot instruction, including branches that resolve while the delay slot is still in flight.

## Interface

Parameters:

- `RESET_PC`, default `64'd0`. PC loaded on reset; the first fetch address.

Ports:

- `clk` — in, 1. Single clock; all state updates on the rising edge.
- `reset` — in, 1. Asynchronous, active-high.
- `Stall_Ctrl` — in, 1. Decode-stage hazard stall. While high, the IF/ID register holds its value.
- `BrTaken_Ctrl` — in, 1. The branch currently in decode is taken.
- `BRANCH_TARGET_ADDRESS` — in, 64. Target of the branch in decode.
- `IMEM_Req` — out, 1. Fetch request is outstanding.
- `IMEM_Addr` — out, 64. Fetch address; always equals the PC.
- `IMEM_Ready` — in, 1. `IMEM_Data` is valid for the current request this cycle.
- `IMEM_Data` — in, 32. Instruction word.
- `INSTRUCTION_PIPELINE_REG` — out, 96. `[95:32]` = PC of the instruction, `[31:0]` = instruction.

## Operation

- States: `S_FETCH` (request outstanding) and `S_HOLD` (response captured while stalled).
- `IMEM_Req` = (state == `S_FETCH`) && !`reset`.
- `IMEM_Addr` stays stable while `IMEM_Req` is high until `IMEM_Ready` is seen.
- next_pc is selected in this priority order:
  - `BrTaken_Ctrl` && !`Stall_Ctrl` → `BRANCH_TARGET_ADDRESS`
  - else `PendBr` → `PendTarget`
  - else PC + 4
  - Bits [1:0] of next_pc are forced to 0.
- A completion is either "`S_FETCH` && `IMEM_Ready` && !`Stall_Ctrl`" or "`S_HOLD` && !`Stall_Ctrl`". On a completion:
  - IF/ID ← {PC, instr}, where instr is `IMEM_Data` or the hold buffer.
  - PC ← next_pc; `PendBr` ← 0; state ← `S_FETCH`.
- `S_FETCH`, `IMEM_Ready`, `Stall_Ctrl`=1: hold buffer ← `IMEM_Data`; state ← `S_HOLD`; PC and IF/ID unchanged.
- `S_FETCH`, !`IMEM_Ready`, !`Stall_Ctrl`: IF/ID ← {PC, `BUBBLE_INSTR`}.
- `S_FETCH`, !`IMEM_Ready`, `Stall_Ctrl`: no change.
- `S_HOLD` && `Stall_Ctrl`: no change; `IMEM_Req` stays low.
- Branch capture: when `BrTaken_Ctrl` && !`Stall_Ctrl` and no completion occurs that cycle, set `PendBr` ← 1 and `PendTarget` ← `BRANCH_TARGET_ADDRESS`.
  - A new capture while `PendBr` is already 1 overwrites it (last wins).
  - `BrTaken_Ctrl` while `Stall_Ctrl` is high is ignored; decode re-presents it after the stall.
- Delay slot: the instruction being fetched when the branch is in decode always completes before the target is fetched.
- `BUBBLE_INSTR` = `32'h910003FF` (ADDI XZR, XZR, #0). A bubble carries the PC of the outstanding fetch.

## Timing

- Reset values:
  - PC = `RESET_PC`; state = `S_FETCH`; `PendBr` = 0; `PendTarget` = 0; hold buffer = 0.
  - IF/ID = {64'd0, `BUBBLE_INSTR`}.
  - `IMEM_Req` = 0 while `reset` is high.
  - `IMEM_Addr` = `RESET_PC` asynchronously.
- First request: `IMEM_Req` rises in the first cycle after `reset` deasserts.
- Latency: `IMEM_Ready` in cycle N → instruction visible in IF/ID after edge N (if not stalled). The next address is presented in cycle N+1.
- Zero-wait memory (`IMEM_Ready` in the same cycle as request) sustains one instruction per cycle with no bubbles.
- Each wait cycle of memory produces exactly one bubble in IF/ID.
- Stall released in `S_HOLD`: the held instruction enters IF/ID on that edge; the new request starts the next cycle. No instruction is lost or duplicated.
- Reset mid-request: the outstanding fetch is aborted and `IMEM_Req` drops immediately. `IMEM_Ready` during reset is ignored; memory must discard the aborted request.
- PC arithmetic is 64-bit modulo; wrap from `64'hFFFF_FFFF_FFFF_FFFC` to 0 is legal.

## Structure

- Shared package `cpu_pipeline_pkg` holds:
  - `BUBBLE_INSTR`
  - `fetch_state_t` enum (`S_FETCH`, `S_HOLD`)
  - IF/ID width constant (96) and field bounds (PC [95:32], instr [31:0])
- One sub-module: `fetch_next_pc`, the combinational next-PC priority selector. It uses the existing `Adder_64` for PC + 4.
- The IF/ID register and PC use asynchronous-reset flops local to this block.

## Test plan

- Zero-wait memory returning data = addr ^ `32'hA5A5_0000`, `RESET_PC`=0 → IF/ID = {0, A5A50000}, {4, A5A50004}, {8, A5A50008} on consecutive edges; no bubbles.
- Two-wait-cycle memory at PC 0x20 → two edges with IF/ID = {0x20, `910003FF`}, then {0x20, data}; the next `IMEM_Addr` is 0x24.
- `Stall_Ctrl`=1 in the same cycle as `IMEM_Ready` at PC 0x8 → IF/ID unchanged and `IMEM_Req` low next cycle. Release stall → IF/ID = {0x8, data}, then `IMEM_Addr` = 0xC.
- Zero-wait memory, branch at 0x10 in decode with `BrTaken_Ctrl`=1 and target 0x100 → fetched PCs are 0x10, 0x14 (delay slot), 0x100, 0x104.
- Three-wait memory, `BrTaken_Ctrl`=1 for one cycle while 0x14 is outstanding → `PendBr`=1. 0x14 then enters IF/ID, the next `IMEM_Addr` = 0x100, and `PendBr` clears.
- Assert `reset` asynchronously mid-wait at PC 0x40 → `IMEM_Req` low immediately, IF/ID = {0, `910003FF`}, PC = `RESET_PC`. After release, the first request is to `RESET_PC`.
